// File: rtl/effect_chain_sequencer.sv
// effect_chain_sequencer: per-sample scheduler for the audio effect path.
// Each captured sample is passed bit-exact through the enabled effect slots
// in ascending slot order. A slot that never answers is bypassed after
// TIMEOUT wait cycles.
// Optional build macro STATUS_COUNT_EN adds a saturating count of dropped
// sample_end pulses on overrun_count. Without the macro that port is tied
// to zero.
module effect_chain_sequencer #(
    parameter int NUM_SLOTS = 4,
    parameter int TIMEOUT   = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sample_end,
    input  logic                        sample_req,
    input  logic signed [15:0]          audio_input,
    output logic signed [15:0]          audio_output,
    input  logic [NUM_SLOTS-1:0]        enable_mask,
    output logic [NUM_SLOTS-1:0]        slot_start,
    output logic signed [15:0]          slot_data_in,
    input  logic [16*NUM_SLOTS-1:0]     slot_data_out,
    input  logic [NUM_SLOTS-1:0]        slot_done,
    output logic                        busy,
    output logic                        overrun,
    output logic                        underrun,
    output logic                        timeout_flag,
    output logic [7:0]                  overrun_count
);

    localparam int DATA_W  = 16;
    localparam int IDX_W   = $clog2(NUM_SLOTS + 1);
    localparam int TIMER_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SCAN, LAUNCH, WAIT} state_t;

    state_t                     state, state_nxt;
    logic [IDX_W-1:0]           idx, idx_nxt;
    logic [TIMER_W-1:0]         timer, timer_nxt;
    logic signed [DATA_W-1:0]   work, work_nxt;
    logic [NUM_SLOTS-1:0]       mask, mask_nxt;
    logic signed [DATA_W-1:0]   audio_output_nxt;
    logic                       timeout_set;
    logic                       sel_en;
    logic                       sel_done;
    logic signed [DATA_W-1:0]   sel_data;

    // Select the mask bit, done and result of the slot addressed by idx.
    // idx == NUM_SLOTS selects nothing.
    always_comb begin
        sel_en   = 1'b0;
        sel_done = 1'b0;
        sel_data = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_en   = mask[k];
                sel_done = slot_done[k];
                sel_data = $signed(slot_data_out[DATA_W*k +: DATA_W]);
            end
        end
    end

    // Next-state logic: walk the slots, launch the enabled ones, and wait
    // for done or bypass on timeout.
    always_comb begin
        state_nxt        = state;
        idx_nxt          = idx;
        timer_nxt        = timer;
        work_nxt         = work;
        mask_nxt         = mask;
        audio_output_nxt = audio_output;
        timeout_set      = 1'b0;
        case (state)
            IDLE: begin
                if (sample_end) begin
                    work_nxt  = audio_input;
                    mask_nxt  = enable_mask;
                    idx_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (idx == IDX_W'(NUM_SLOTS)) begin
                    audio_output_nxt = work;
                    state_nxt        = IDLE;
                end else if (sel_en) begin
                    state_nxt = LAUNCH;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            LAUNCH: begin
                timer_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (sel_done) begin
                    work_nxt  = sel_data;
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = SCAN;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    // The slot did not answer in time; the sample passes through unchanged.
                    timeout_set = 1'b1;
                    idx_nxt     = idx + IDX_W'(1);
                    state_nxt   = SCAN;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Drive slot-facing outputs and busy from the current state.
    // The shared data bus is zero except during LAUNCH and WAIT.
    always_comb begin
        busy         = (state != IDLE);
        slot_start   = '0;
        slot_data_in = '0;
        if (state == LAUNCH || state == WAIT) begin
            slot_data_in = work;
        end
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_start[k] = (state == LAUNCH) && (idx == IDX_W'(k));
        end
    end

    // Control registers, committed output and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            audio_output <= '0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            audio_output <= audio_output_nxt;
            if (sample_end && busy) begin
                overrun <= 1'b1;
            end
            if (sample_req && busy) begin
                underrun <= 1'b1;
            end
            if (timeout_set) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    // Working sample, latched mask and wait timer.
    // These are datapath registers and are always initialised before use.
    always_ff @(posedge clk) begin
        work  <= work_nxt;
        mask  <= mask_nxt;
        timer <= timer_nxt;
    end

`ifdef STATUS_COUNT_EN
    logic [7:0] ovr_cnt;

    // Saturating count of sample_end pulses dropped while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt <= '0;
        end else if (sample_end && busy && ovr_cnt != 8'hFF) begin
            ovr_cnt <= ovr_cnt + 8'd1;
        end
    end

    assign overrun_count = ovr_cnt;
`else
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_effect_chain_sequencer.sv
// Bench for effect_chain_sequencer.
// Effect slots are modelled by simple responders. A sample-level reference
// model predicts busy, the committed output, the flags, the start pulses
// and the slot bus contents on every cycle.
module tb_effect_chain_sequencer;

    localparam int NS = 4;
    localparam int TO = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_end;
    logic               sample_req;
    logic [15:0]        audio_input;
    logic [15:0]        audio_output;
    logic [NS-1:0]      enable_mask;
    logic [NS-1:0]      slot_start;
    logic [15:0]        slot_data_in;
    logic [16*NS-1:0]   slot_data_out;
    logic [NS-1:0]      slot_done;
    logic               busy, overrun, underrun, timeout_flag;
    logic [7:0]         overrun_count;

    logic [NS-1:0]      resp_done;
    logic [NS-1:0]      spur;
    int                 dly[NS];
    int                 op[NS];
    int                 cnt[NS];
    logic [15:0]        cap[NS];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    effect_chain_sequencer #(.NUM_SLOTS(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .sample_end(sample_end), .sample_req(sample_req),
        .audio_input(audio_input), .audio_output(audio_output),
        .enable_mask(enable_mask), .slot_start(slot_start),
        .slot_data_in(slot_data_in), .slot_data_out(slot_data_out),
        .slot_done(slot_done), .busy(busy), .overrun(overrun),
        .underrun(underrun), .timeout_flag(timeout_flag),
        .overrun_count(overrun_count)
    );

    function automatic logic [15:0] fx(int o, logic [15:0] x);
        case (o)
            0:       return x + 16'd1;
            1:       return x << 1;
            2:       return x ^ 16'h00FF;
            default: return x - 16'd3;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Effect slot responders: done pulses dly[k] cycles after start (0 = never).
    always @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (reset) begin
                cnt[k] <= 0;
            end else if (slot_start[k]) begin
                cnt[k] <= dly[k];
                cap[k] <= slot_data_in;
            end else if (cnt[k] > 0) begin
                cnt[k] <= cnt[k] - 1;
            end
        end
    end

    always_comb begin
        resp_done     = '0;
        slot_data_out = '0;
        for (int k = 0; k < NS; k++) begin
            resp_done[k]            = (cnt[k] == 1);
            slot_data_out[16*k +: 16] = fx(op[k], cap[k]);
        end
    end

    assign slot_done = resp_done | spur;

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          pend = 0;
    int          commit_e = -1;
    int          tmo_e = -1;
    logic [15:0] pend_val = '0;
    logic [15:0] m_out = '0;
    bit          m_ovr = 0, m_und = 0, m_tmo = 0;
    int          m_cnt = 0;
    int          launch_after[NS];
    int          wnd[NS];
    logic [15:0] sin[NS];

    // Schedule one sample: every slot costs one scan cycle; an enabled slot
    // adds a launch cycle plus its wait (TO when it never answers in time).
    task automatic model_capture(int c, logic [15:0] x, logic [NS-1:0] m);
        int t;
        int w;
        logic [15:0] cur;
        t = c;
        cur = x;
        tmo_e = -1;
        for (int k = 0; k < NS; k++) begin
            launch_after[k] = -1;
            t++;
            if (m[k]) begin
                launch_after[k] = t;
                t++;
                sin[k] = cur;
                if (dly[k] > 0 && dly[k] <= TO) begin
                    w = dly[k];
                    cur = fx(op[k], cur);
                end else begin
                    w = TO;
                    if (tmo_e < 0) tmo_e = t + w;
                end
                wnd[k] = w;
                t += w;
            end
        end
        t++;
        commit_e = t;
        pend_val = cur;
        pend = 1;
    endtask

    always @(posedge clk) begin
        bit busy_b;
        cyc++;
        if (reset) begin
            pend = 0; commit_e = -1; tmo_e = -1;
            m_out = '0; m_ovr = 0; m_und = 0; m_tmo = 0; m_cnt = 0;
            for (int k = 0; k < NS; k++) launch_after[k] = -1;
        end else begin
            busy_b = pend && (cyc <= commit_e);
            if (pend && cyc == tmo_e) m_tmo = 1;
            if (pend && cyc == commit_e) m_out = pend_val;
            if (sample_end) begin
                if (busy_b) begin
                    m_ovr = 1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    model_capture(cyc, audio_input, enable_mask);
                end
            end
            if (sample_req && busy_b) m_und = 1;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        logic [NS-1:0] st_exp;
        int exp_cnt;
        if (cyc > 0) begin
`ifdef STATUS_COUNT_EN
            exp_cnt = m_cnt;
`else
            exp_cnt = 0;
`endif
            check("busy", busy, pend && (cyc < commit_e));
            check("audio_output", audio_output, m_out);
            check("overrun", overrun, m_ovr);
            check("underrun", underrun, m_und);
            check("timeout_flag", timeout_flag, m_tmo);
            check("overrun_count", overrun_count, exp_cnt);
            st_exp = '0;
            for (int k = 0; k < NS; k++) begin
                st_exp[k] = pend && (launch_after[k] == cyc);
                if (pend && launch_after[k] >= 0 && cyc >= launch_after[k]
                    && cyc <= launch_after[k] + wnd[k])
                    check("slot_data_in", slot_data_in, sin[k]);
            end
            check("slot_start", slot_start, st_exp);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [NS-1:0] slog[$];
    logic [15:0]   sdi2;

    task automatic run_sample(input logic [15:0] x, input logic [NS-1:0] later_mask,
                              output int nb);
        @(negedge clk);
        audio_input = x;
        sample_end  = 1'b1;
        @(negedge clk);
        sample_end  = 1'b0;
        enable_mask = later_mask;
        slog.delete();
        nb = 0;
        while (busy && nb < 300) begin
            if (slot_start != '0) slog.push_back(slot_start);
            if (slot_start[2]) sdi2 = slot_data_in;
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        check(name, busy, 1'b0);
    endtask

    initial begin
        int nb;
        int n;
        reset = 1'b1; sample_end = 1'b0; sample_req = 1'b0;
        audio_input = '0; enable_mask = '0; spur = '0; sdi2 = '0;
        for (int k = 0; k < NS; k++) begin dly[k] = 0; op[k] = k; end
        repeat (3) @(negedge clk);
        check("rst_out", audio_output, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_start", slot_start, 4'b0000);
        check("rst_sdi", slot_data_in, 16'h0000);
        check("rst_flags", {overrun, underrun, timeout_flag}, 3'b000);
        reset = 1'b0;

        // All slots disabled: pure pass-through after NUM_SLOTS+1 cycles.
        enable_mask = 4'b0000;
        run_sample(16'h1234, 4'b0000, nb);
        check("t1_busy_cycles", nb, 5);
        check("t1_out", audio_output, 16'h1234);
        check("t1_no_start", slog.size(), 0);

        // Slots 0 and 2; mask change mid-chain and stray dones are ignored.
        dly[0] = 3; op[0] = 0; dly[2] = 1; op[2] = 1;
        spur = 4'b1010;
        enable_mask = 4'b0101;
        run_sample(16'h0010, 4'b1111, nb);
        spur = '0;
        check("t2_busy_cycles", nb, 11);
        check("t2_out", audio_output, 16'h0022);
        check("t2_nstarts", slog.size(), 2);
        if (slog.size() == 2) begin
            check("t2_start0", slog[0], 4'b0001);
            check("t2_start1", slog[1], 4'b0100);
        end
        check("t2_sdi_slot2", sdi2, 16'h0011);
        check("t2_no_timeout", timeout_flag, 1'b0);

        // Slot 1 never answers: bypass after TO wait cycles.
        dly[1] = 0;
        enable_mask = 4'b0010;
        run_sample(16'h0ABC, 4'b0010, nb);
        check("t3_busy_cycles", nb, 14);
        check("t3_out", audio_output, 16'h0ABC);
        check("t3_timeout", timeout_flag, 1'b1);

        // Second sample_end while slot 0 waits: dropped.
        dly[0] = 5; op[0] = 0;
        enable_mask = 4'b0001;
        check("t4_ovr_before", overrun, 1'b0);
        @(negedge clk);
        audio_input = 16'h0100; sample_end = 1'b1;
        @(negedge clk);
        sample_end = 1'b0;
        repeat (2) @(negedge clk);
        audio_input = 16'h7777; sample_end = 1'b1;
        @(negedge clk);
        sample_end = 1'b0;
        wait_idle("t4_idle");
        check("t4_out", audio_output, 16'h0101);
        check("t4_overrun", overrun, 1'b1);
`ifdef STATUS_COUNT_EN
        check("t4_count", overrun_count, 8'd1);
`else
        check("t4_count", overrun_count, 8'd0);
`endif
        repeat (5) @(negedge clk);
        check("t4_second_dropped", busy, 1'b0);

        // sample_req during WAIT: underrun, output keeps previous result.
        dly[0] = 4;
        check("t5_und_before", underrun, 1'b0);
        @(negedge clk);
        audio_input = 16'h0200; sample_end = 1'b1;
        @(negedge clk);
        sample_end = 1'b0;
        repeat (3) @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        check("t5_out_mid", audio_output, 16'h0101);
        check("t5_underrun", underrun, 1'b1);
        wait_idle("t5_idle");
        check("t5_out", audio_output, 16'h0201);

        // sample_end held high: back-to-back captures and many drops.
        enable_mask = 4'b0000;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            audio_input = 16'(i);
            sample_end  = 1'b1;
        end
        @(negedge clk);
        sample_end = 1'b0;
        wait_idle("t6_idle");
`ifdef STATUS_COUNT_EN
        check("t6_count_sat", overrun_count, 8'd255);
`else
        check("t6_count_sat", overrun_count, 8'd0);
`endif

        // Reset during LAUNCH of slot 1 aborts the chain.
        dly[1] = 4; op[1] = 2;
        enable_mask = 4'b0010;
        @(negedge clk);
        audio_input = 16'h5555; sample_end = 1'b1;
        @(negedge clk);
        sample_end = 1'b0;
        n = 0;
        while (!slot_start[1] && n < 20) begin n++; @(negedge clk); end
        check("t7_reached_launch", slot_start, 4'b0010);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t7_start", slot_start, 4'b0000);
        check("t7_busy", busy, 1'b0);
        check("t7_out", audio_output, 16'h0000);
        check("t7_flags", {overrun, underrun, timeout_flag}, 3'b000);
        check("t7_count", overrun_count, 8'd0);
        repeat (10) @(negedge clk);

        // Normal sample after reset; signed wrap passes bit-exact.
        dly[0] = 2; op[0] = 0;
        enable_mask = 4'b0001;
        run_sample(16'h7FFF, 4'b0001, nb);
        check("t8_busy_cycles", nb, 8);
        check("t8_out", audio_output, 16'h8000);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
